// File: rtl/line_clear_engine.sv
// ============================================================================
//  Module   : line_clear_engine
//  Purpose  : Removes completed rows from a board snapshot, compacts the
//             survivors toward the bottom and strobes the result out.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module line_clear_engine #(
   parameter int ROWS = 20,
   parameter int COLS = 10,
   parameter int CW   = 4,
   parameter int CNTW = 5
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Start,
   input  logic                     reset_game,
   input  logic [ROWS*COLS*CW-1:0]  BoardIn,
   output logic [ROWS*COLS*CW-1:0]  BoardOut,
   output logic                     LoadReg,
   output logic                     Busy,
   output logic                     Done,
   output logic [CNTW-1:0]          LinesCleared
);

   localparam int IDXW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [IDXW-1:0] c_LAST = IDXW'(ROWS - 1);

   typedef logic [COLS-1:0][CW-1:0] row_t;
   typedef row_t [ROWS-1:0]         board_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   board_t            r_src;
   board_t            r_dst;
   logic [IDXW-1:0]   r_rd;
   logic [IDXW-1:0]   r_wr;
   logic [CNTW-1:0]   r_cnt;
   logic [CNTW-1:0]   r_lines;
   row_t              w_srcRow;
   logic              w_rowFull;
   logic [CNTW-1:0]   w_cntNext;

   always_comb begin
      w_srcRow  = r_src[r_rd];
      w_rowFull = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (w_srcRow[c] == '0) w_rowFull = 1'b0;
      end
      w_cntNext = r_cnt + (w_rowFull ? CNTW'(1) : CNTW'(0));
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_nextState;
   end

   // An abort in the commit cycle also suppresses the strobes of that cycle.
   always_comb begin
      w_nextState = r_state;
      Busy        = 1'b0;
      Done        = 1'b0;
      LoadReg     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) w_nextState = S_SCAN;
         end
         S_SCAN: begin
            Busy = 1'b1;
            if (r_rd == '0) w_nextState = S_COMMIT;
         end
         S_COMMIT: begin
            Busy        = 1'b1;
            Done        = ~reset_game;
            LoadReg     = ~reset_game && (r_cnt != '0);
            w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
      if (reset_game) w_nextState = S_IDLE;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_src   <= '0;
         r_dst   <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
         r_cnt   <= '0;
         r_lines <= '0;
      end else if (reset_game) begin
         r_dst   <= '0;
         r_lines <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_src <= BoardIn;
                  r_dst <= '0;
                  r_rd  <= c_LAST;
                  r_wr  <= c_LAST;
                  r_cnt <= '0;
               end
            end
            S_SCAN: begin
               // Write pointer saturates at the top row so it never wraps.
               if (w_rowFull) begin
                  r_cnt <= w_cntNext;
               end else begin
                  r_dst[r_wr] <= w_srcRow;
                  if (r_wr != '0) r_wr <= r_wr - IDXW'(1);
               end
               if (r_rd != '0) r_rd <= r_rd - IDXW'(1);
               else            r_lines <= w_cntNext;
            end
            default: ;
         endcase
      end
   end

   assign BoardOut     = r_dst;
   assign LinesCleared = r_lines;

endmodule

`default_nettype wire

// File: tb/tb_line_clear_engine.sv
// ============================================================================
//  Module   : tb_line_clear_engine
//  Purpose  : Directed self-checking bench for line_clear_engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_line_clear_engine;

   localparam int ROWS = 20;
   localparam int COLS = 10;
   localparam int CW   = 4;
   localparam int CNTW = 5;

   typedef logic [COLS-1:0][CW-1:0] row_t;
   typedef row_t [ROWS-1:0]         board_t;

   logic            Clk = 1'b0;
   logic            Reset = 1'b1;
   logic            Start = 1'b0;
   logic            reset_game = 1'b0;
   board_t          BoardIn = '0;
   logic [ROWS*COLS*CW-1:0] BoardOut;
   logic            LoadReg;
   logic            Busy;
   logic            Done;
   logic [CNTW-1:0] LinesCleared;

   int checks = 0;
   int failures = 0;

   // results of the last run_op
   int              busyCycles, doneCount, loadCount, doneCycle, loadCycle;
   board_t          outBoard;
   logic [CNTW-1:0] outLines, linesDuring;

   line_clear_engine #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .CNTW(CNTW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .reset_game(reset_game),
      .BoardIn(BoardIn), .BoardOut(BoardOut), .LoadReg(LoadReg),
      .Busy(Busy), .Done(Done), .LinesCleared(LinesCleared)
   );

   always #5 Clk = ~Clk;

   function automatic row_t fullRow(input logic [CW-1:0] colour);
      row_t r;
      for (int c = 0; c < COLS; c++) r[c] = colour;
      return r;
   endfunction

   // Accepts one operation and observes 30 cycles; extra Start / abort pulses optional.
   task automatic run_op(input board_t b, input int startAt, input int abortAt);
      busyCycles = 0; doneCount = 0; loadCount = 0; doneCycle = -1; loadCycle = -1;
      outBoard = '0; outLines = '1; linesDuring = '1;
      @(negedge Clk);
      BoardIn = b;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         if (cyc == 1) linesDuring = LinesCleared;
         if (Busy) busyCycles++;
         if (Done) begin
            doneCount++; doneCycle = cyc;
            outBoard = board_t'(BoardOut); outLines = LinesCleared;
         end
         if (LoadReg) begin
            loadCount++; loadCycle = cyc;
         end
         BoardIn    = ~b;
         Start      = (cyc == startAt);
         reset_game = (cyc == abortAt);
         @(negedge Clk);
      end
      Start = 1'b0;
      reset_game = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
      checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
      checks++; if (LoadReg !== 1'b0) begin failures++; $display("FAIL reset_load got=%b exp=0", LoadReg); end
      checks++; if (LinesCleared !== '0) begin failures++; $display("FAIL reset_lines got=%0d exp=0", LinesCleared); end
      checks++; if (BoardOut !== '0) begin failures++; $display("FAIL reset_board got=%h exp=0", BoardOut); end
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
   endtask

   task automatic test_empty();
      run_op('0, -1, -1);
      checks++; if (busyCycles !== 21) begin failures++; $display("FAIL empty_busy got=%0d exp=21", busyCycles); end
      checks++; if (doneCount !== 1) begin failures++; $display("FAIL empty_done_count got=%0d exp=1", doneCount); end
      checks++; if (doneCycle !== 21) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=21", doneCycle); end
      checks++; if (loadCount !== 0) begin failures++; $display("FAIL empty_load got=%0d exp=0", loadCount); end
      checks++; if (outLines !== 5'd0) begin failures++; $display("FAIL empty_lines got=%0d exp=0", outLines); end
   endtask

   task automatic test_one_line();
      board_t b, e;
      b = '0; e = '0;
      b[19] = fullRow(4'd3);
      b[18][9] = 4'd5;
      e[19][9] = 4'd5;
      run_op(b, -1, -1);
      checks++; if (loadCount !== 1) begin failures++; $display("FAIL one_load_count got=%0d exp=1", loadCount); end
      checks++; if (loadCycle !== 21) begin failures++; $display("FAIL one_load_cycle got=%0d exp=21", loadCycle); end
      checks++; if (outBoard !== e) begin failures++; $display("FAIL one_board got=%h exp=%h", outBoard, e); end
      checks++; if (outLines !== 5'd1) begin failures++; $display("FAIL one_lines got=%0d exp=1", outLines); end
      checks++; if (BoardOut !== e) begin failures++; $display("FAIL one_board_hold got=%h exp=%h", BoardOut, e); end
      checks++; if (LinesCleared !== 5'd1) begin failures++; $display("FAIL one_lines_hold got=%0d exp=1", LinesCleared); end
   endtask

   task automatic test_two_lines();
      board_t b, e;
      b = '0; e = '0;
      b[19] = fullRow(4'd7);
      b[17] = fullRow(4'd8);
      b[18] = fullRow(4'd2); b[18][9] = 4'd0;
      b[16][9] = 4'd1;
      e[19] = b[18];
      e[18] = b[16];
      run_op(b, -1, -1);
      checks++; if (linesDuring !== 5'd1) begin failures++; $display("FAIL two_lines_during got=%0d exp=1", linesDuring); end
      checks++; if (outBoard !== e) begin failures++; $display("FAIL two_board got=%h exp=%h", outBoard, e); end
      checks++; if (outLines !== 5'd2) begin failures++; $display("FAIL two_lines got=%0d exp=2", outLines); end
   endtask

   task automatic test_tetris();
      board_t b, e;
      b = '0; e = '0;
      for (int r = 16; r < 20; r++) b[r] = fullRow(4'(r - 10));
      b[15][0] = 4'd6;
      b[14][3] = 4'd9;
      e[19][0] = 4'd6;
      e[18][3] = 4'd9;
      run_op(b, -1, -1);
      checks++; if (outBoard !== e) begin failures++; $display("FAIL tetris_board got=%h exp=%h", outBoard, e); end
      checks++; if (outLines !== 5'd4) begin failures++; $display("FAIL tetris_lines got=%0d exp=4", outLines); end
      checks++; if (loadCount !== 1) begin failures++; $display("FAIL tetris_load got=%0d exp=1", loadCount); end
   endtask

   task automatic test_all_full();
      board_t b;
      for (int r = 0; r < ROWS; r++) b[r] = fullRow(4'((r % 15) + 1));
      run_op(b, -1, -1);
      checks++; if (outBoard !== '0) begin failures++; $display("FAIL full_board got=%h exp=0", outBoard); end
      checks++; if (outLines !== 5'd20) begin failures++; $display("FAIL full_lines got=%0d exp=20", outLines); end
      checks++; if (loadCount !== 1) begin failures++; $display("FAIL full_load got=%0d exp=1", loadCount); end
   endtask

   task automatic test_back_to_back();
      board_t b, e;
      b = '0; e = '0;
      b[19] = fullRow(4'd12);
      b[0][0] = 4'd4;
      e[1][0] = 4'd4;
      run_op(b, 5, -1);
      checks++; if (doneCount !== 1) begin failures++; $display("FAIL b2b_done got=%0d exp=1", doneCount); end
      checks++; if (loadCount !== 1) begin failures++; $display("FAIL b2b_load got=%0d exp=1", loadCount); end
      checks++; if (busyCycles !== 21) begin failures++; $display("FAIL b2b_busy got=%0d exp=21", busyCycles); end
      checks++; if (doneCycle !== 21) begin failures++; $display("FAIL b2b_done_cycle got=%0d exp=21", doneCycle); end
      checks++; if (outBoard !== e) begin failures++; $display("FAIL b2b_board got=%h exp=%h", outBoard, e); end
   endtask

   task automatic test_reset_game();
      board_t b;
      b = '0;
      b[19] = fullRow(4'd9);
      run_op(b, -1, 10);
      checks++; if (busyCycles !== 10) begin failures++; $display("FAIL abort_busy got=%0d exp=10", busyCycles); end
      checks++; if (doneCount !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", doneCount); end
      checks++; if (loadCount !== 0) begin failures++; $display("FAIL abort_load got=%0d exp=0", loadCount); end
      checks++; if (LinesCleared !== 5'd0) begin failures++; $display("FAIL abort_lines got=%0d exp=0", LinesCleared); end
      checks++; if (BoardOut !== '0) begin failures++; $display("FAIL abort_board got=%h exp=0", BoardOut); end
   endtask

   task automatic test_async_reset();
      board_t b, e;
      b = '0; e = '0;
      b[19] = fullRow(4'd1);
      b[18] = fullRow(4'd2);
      b[17][5] = 4'd11;
      e[19][5] = 4'd11;
      run_op(b, -1, -1);
      @(negedge Clk);
      BoardIn = b;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (8) @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", Busy); end
      checks++; if (BoardOut !== '0) begin failures++; $display("FAIL areset_board got=%h exp=0", BoardOut); end
      checks++; if (LinesCleared !== 5'd0) begin failures++; $display("FAIL areset_lines got=%0d exp=0", LinesCleared); end
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      run_op(b, -1, -1);
      checks++; if (outLines !== 5'd2) begin failures++; $display("FAIL areset_rerun_lines got=%0d exp=2", outLines); end
      checks++; if (outBoard !== e) begin failures++; $display("FAIL areset_rerun_board got=%h exp=%h", outBoard, e); end
      checks++; if (loadCount !== 1) begin failures++; $display("FAIL areset_rerun_load got=%0d exp=1", loadCount); end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_one_line();
      test_two_lines();
      test_tetris();
      test_all_full();
      test_back_to_back();
      test_reset_game();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
